// File: rtl/booth_r4_seq_approx.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, signed/unsigned operands,
// runtime perforation of the K least-significant digits, valid/ready on both sides.
module booth_r4_seq_approx #(
    parameter int WIDTH = 16,
    parameter int KW    = $clog2(WIDTH/2+2)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [WIDTH-1:0]   in_y,
    input  logic               in_tc,
    input  logic [KW-1:0]      in_k,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy
);
    localparam int XW = WIDTH + 2;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e        r_state, w_state_nxt;
    logic [XW-1:0] r_x, w_x_nxt;
    logic [XW-1:0] r_y, w_y_nxt;
    logic [KW-1:0] r_j, w_j_nxt;
    logic [KW-1:0] r_nd, w_nd_nxt;
    logic [PW-1:0] r_acc, w_acc_nxt;

    logic [XW-1:0] w_x_ext, w_y_ext;
    logic [KW-1:0] w_nd_in, w_keff;
    logic [XW:0]   w_ye, w_ye_sh;
    logic [KW:0]   w_bit;
    logic [2:0]    w_trip;
    logic          w_neg, w_zero, w_two;
    logic [PW-1:0] w_xs, w_sh, w_pp, w_acc_add;

    assign w_x_ext = in_tc ? {{2{in_x[WIDTH-1]}}, in_x} : {2'b00, in_x};
    assign w_y_ext = in_tc ? {{2{in_y[WIDTH-1]}}, in_y} : {2'b00, in_y};
    assign w_nd_in = in_tc ? KW'(WIDTH/2) : KW'(WIDTH/2 + 1);
    assign w_keff  = (in_k > w_nd_in) ? w_nd_in : in_k;

    // Booth triplet y[2j+1:2j-1], with an implicit zero below bit 0.
    assign w_ye    = {r_y, 1'b0};
    assign w_bit   = {r_j, 1'b0};
    assign w_ye_sh = w_ye >> w_bit;
    assign w_trip  = w_ye_sh[2:0];

    assign w_zero = (w_trip == 3'b000) || (w_trip == 3'b111);
    assign w_two  = (w_trip == 3'b011) || (w_trip == 3'b100);
    assign w_neg  = w_trip[2] && !w_zero;

    // Negative digits: invert the aligned magnitude and add one as carry-in.
    assign w_xs      = {{(PW-XW){r_x[XW-1]}}, r_x};
    assign w_sh      = (w_two ? (w_xs << 1) : w_xs) << w_bit;
    assign w_pp      = w_zero ? '0 : (w_neg ? ~w_sh : w_sh);
    assign w_acc_add = r_acc + w_pp + PW'(w_neg);

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_j_nxt     = r_j;
        w_nd_nxt    = r_nd;
        w_acc_nxt   = r_acc;
        unique case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_x_nxt     = w_x_ext;
                    w_y_nxt     = w_y_ext;
                    w_j_nxt     = w_keff;
                    w_nd_nxt    = w_nd_in;
                    w_acc_nxt   = '0;
                    w_state_nxt = (w_keff == w_nd_in) ? StDone : StCalc;
                end
            end
            StCalc: begin
                w_acc_nxt = w_acc_add;
                w_j_nxt   = r_j + KW'(1);
                if (r_j == r_nd - KW'(1)) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_x     <= '0;
            r_y     <= '0;
            r_j     <= '0;
            r_nd    <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_j     <= w_j_nxt;
            r_nd    <= w_nd_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign busy      = (r_state != StIdle);
    assign out_p     = r_acc;

endmodule

// File: tb/tb_booth_r4_seq_approx.sv
// Directed bench for booth_r4_seq_approx (WIDTH=16) with hand-computed products and latencies.
module tb_booth_r4_seq_approx;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_y;
    logic        in_tc;
    logic [3:0]  in_k;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_p;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    booth_r4_seq_approx #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_tc     (in_tc),
        .in_k      (in_k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Accepts one transaction, measures edges to out_valid (accept edge counts as 1),
    // checks the product, then completes the output handshake.
    task automatic txn(input string tag, input logic [15:0] x, input logic [15:0] y,
                       input logic tc, input logic [3:0] k,
                       input logic [31:0] exp_p, input int exp_lat);
        int lat;
        in_x = x; in_y = y; in_tc = tc; in_k = k; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_x = 16'hA5A5; in_y = 16'h5A5A; in_k = 4'd0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_in_ready_low"}, 64'(in_ready), 64'd0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_p"}, 64'(out_p), 64'(exp_p));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        chk({tag, "_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        int stale;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_x = '0; in_y = '0; in_tc = 1'b0; in_k = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_p", 64'(out_p), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        txn("signed_m3x5", 16'hFFFD, 16'h0005, 1'b1, 4'd0, 32'hFFFF_FFF1, 9);
        txn("unsigned_max", 16'hFFFF, 16'hFFFF, 1'b0, 4'd0, 32'hFFFE_0001, 10);
        txn("signed_min", 16'h8000, 16'h8000, 1'b1, 4'd0, 32'h4000_0000, 9);
        txn("perf_k1", 16'h0003, 16'h0005, 1'b1, 4'd1, 32'h0000_000C, 8);
        // y=0xFFFF unsigned: d0=-1, d8=+1, rest 0; dropping d0 leaves x*2^16.
        txn("perf_u_k1", 16'hFFFF, 16'hFFFF, 1'b0, 4'd1, 32'hFFFF_0000, 9);
        txn("full_perf_s", 16'h1234, 16'h5678, 1'b1, 4'd15, 32'h0000_0000, 1);
        txn("full_perf_u", 16'h1234, 16'h5678, 1'b0, 4'd9, 32'h0000_0000, 1);
        txn("signed_m1xm1", 16'hFFFF, 16'hFFFF, 1'b1, 4'd0, 32'h0000_0001, 9);

        // Backpressure: result held, new operands ignored while DONE waits.
        in_x = 16'd7; in_y = 16'd6; in_tc = 1'b0; in_k = 4'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_latency", 64'(lat), 64'd10);
        in_x = 16'd1; in_y = 16'd1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_p_stable", 64'(out_p), 64'h2A);
            chk("bp_valid_held", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_idle", 64'(in_ready), 64'd1);
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("bp_no_ghost", 64'(busy), 64'd0);
        txn("bp_second", 16'h0064, 16'hFFF6, 1'b1, 4'd0, 32'hFFFF_FC18, 9);

        // Reset during the third CALC iteration.
        in_x = 16'h1234; in_y = 16'h4321; in_tc = 1'b0; in_k = 4'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        chk("midrst_no_stale", 64'(stale), 64'd0);
        txn("after_rst", 16'h0007, 16'h0006, 1'b0, 4'd0, 32'h0000_002A, 10);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/booth_r4_seq_approx.md
Name: booth_r4_seq_approx

Overview:
- Parametrised, multi-cycle radix-4 Booth multiplier. It is the sequential successor to the fixed 16x16 combinational approximate Booth multipliers in the non-logarithmic family.
- It retires one Booth digit per clock through a single partial-product adder.
- It supports signed and unsigned operands per transaction.
- It supports runtime partial-product perforation: the K least-significant Booth digits are dropped.
- It sits behind a valid/ready handshake on both sides, for use in error-resilient datapaths that trade accuracy for latency.

Parameters:
- WIDTH, 16, operand width in bits; must be even and >= 4.
- KW, $clog2(WIDTH/2+2), width of the perforation-count input.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  block can accept operands.
- in_x  in  WIDTH  multiplicand.
- in_y  in  WIDTH  multiplier (Booth-recoded).
- in_tc  in  1  1 = two's-complement operands, 0 = unsigned.
- in_k  in  KW  number of low Booth digits to perforate (drop).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_p  out  2*WIDTH  product, two's complement if tc=1, unsigned otherwise.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
- Reset values (rst_n low at an edge):
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0; out_p = 0; internal registers cleared.
  - Applies mid-operation: any in-flight transaction is discarded, and no out_valid follows it.
- Operand extension: operands are extended to WIDTH+2 bits, sign-extended if tc=1 and zero-extended if tc=0.
- Digit count: ND = WIDTH/2 if tc=1, WIDTH/2+1 if tc=0.
- Booth digit: d_j = -2*y[2j+1] + y[2j] + y[2j-1], with y[-1] = 0, for j = 0..ND-1. Each d_j is in {-2,-1,0,1,2}.
- Effective perforation: Keff = min(in_k, ND). Digits j < Keff are treated as 0.
- Result: out_p = sum over j = Keff..ND-1 of d_j * x * 4^j, exact modulo 2^(2*WIDTH). No overflow is possible for either mode when Keff = 0.
- Iterations: N = ND - Keff.
- Partial-product form: each partial product is formed as the negate/shift select of x (invert plus carry-in for negative digits). Add it into the accumulator, aligned by 2j, in the cycle that digit is processed. Digit order is free, but exactly one digit is processed per CALC cycle.
- FSM IDLE:
  - in_ready = 1.
  - On in_valid at an edge: latch x, y, tc and Keff; clear the accumulator.
  - Next state is CALC if N > 0, DONE if N = 0.
- FSM CALC:
  - in_ready = 0.
  - The counter steps through the remaining digits.
  - After the N-th digit edge, go to DONE.
- FSM DONE:
  - out_valid = 1.
  - out_p is held stable while out_valid=1 and out_ready=0.
  - On out_ready at an edge: go to IDLE; out_valid drops next cycle.
- Latency: out_valid is first high N+1 edges after the accepting edge.
- Throughput: no overlap. in_ready stays low from the accept edge until the edge after the result handshake.
- in_valid is ignored outside IDLE. Inputs are only sampled at the accept edge, so later changes to inputs have no effect.
- out_p may hold the last result or 0 when out_valid=0; the bench checks it only while out_valid=1.

Test Plan:
- Exact signed: WIDTH=16, tc=1, k=0, x=-3, y=5 -> out_p = 0xFFFFFFF1; out_valid 9 edges after accept.
- Exact unsigned: tc=0, k=0, x=0xFFFF, y=0xFFFF -> out_p = 0xFFFE0001; latency 10 edges.
- Corner signed: tc=1, k=0, x=y=0x8000 -> 0x40000000. Then perforation: tc=1, x=3, y=5, k=1 -> 0x0000000C (digit d0=1 dropped, d1=1 kept); latency 8 edges.
- Full perforation: tc=1, k=15 (saturates to 8) -> out_p = 0, out_valid after 1 edge. Also tc=0, k=9 -> 0 after 1 edge.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_p and out_valid stable, in_ready=0, and new in_valid ignored. Release -> IDLE next edge; a second transaction then completes correctly.
- Reset mid-CALC: assert rst_n=0 for one edge at iteration 3 -> in_ready=1, out_valid=0, busy=0; no stale result appears; the next transaction is exact.
